// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared defaults and bus-slot helper for the writeback port arbiter
package wb_arb_pkg;
  localparam int NREQ_DEF = 3;
  localparam int AW_DEF = 5;
  localparam int DW_DEF = 32;
  localparam int BUSW = 256;
  function automatic logic [63:0] get_slot(input logic [BUSW-1:0] bus, input int i, input int w);
    logic [BUSW-1:0] s;
    s = bus >> (i * w);
    return s[63:0] & ((64'd1 << w) - 64'd1);
  endfunction
endpackage

// File: rtl/gnrl_rr_pick.sv
// gnrl_rr_pick: combinational round-robin pick starting at ptr
module gnrl_rr_pick #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] vld,
  input  logic [1:0]      ptr,
  output logic [NREQ-1:0] gnt,
  output logic            found,
  output logic [1:0]      idx
);
  always_comb begin
    int j;
    gnt = '0;
    found = 1'b0;
    idx = 2'd0;
    j = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!found && vld[j]) begin
        found = 1'b1;
        idx = 2'(j);
        gnt[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/wb_port_arb.sv
// wb_port_arb: round-robin arbiter for the register-file write port
module wb_port_arb
  import wb_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int CW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [NREQ-1:0]    req_vld,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_rdy,
  output logic             wb_en,
  output logic [AW-1:0]    wb_addr,
  output logic [DW-1:0]    wb_data,
  output logic [CW-1:0]    cont_cnt
);
  logic [1:0] ptr_q, ptr_d, idx;
  logic [NREQ-1:0] gnt;
  logic found, xfer, wb_en_d;
  logic [AW-1:0] addr_g, wb_addr_d;
  logic [DW-1:0] data_g, wb_data_d;
  logic [CW-1:0] cont_cnt_d;
  gnrl_rr_pick #(.NREQ(NREQ)) u_pick (
    .vld(req_vld),
    .ptr(ptr_q),
    .gnt(gnt),
    .found(found),
    .idx(idx)
  );
  always_comb begin
    xfer = found & ~stall & ~rst;
    req_rdy = xfer ? gnt : '0;
    addr_g = AW'(get_slot(BUSW'(req_addr), int'(idx), AW));
    data_g = DW'(get_slot(BUSW'(req_data), int'(idx), DW));
    ptr_d = xfer ? ((idx == 2'(NREQ - 1)) ? 2'd0 : idx + 2'd1) : ptr_q;
    wb_en_d = xfer & (addr_g != '0);
    wb_addr_d = xfer ? addr_g : wb_addr;
    wb_data_d = xfer ? data_g : wb_data;
    cont_cnt_d = (!stall && $countones(req_vld) > 1 && cont_cnt != '1) ? cont_cnt + 1'b1 : cont_cnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 2'd0;
      wb_en <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      cont_cnt <= '0;
    end else begin
      ptr_q <= ptr_d;
      wb_en <= wb_en_d;
      wb_addr <= wb_addr_d;
      wb_data <= wb_data_d;
      cont_cnt <= cont_cnt_d;
    end
  end
endmodule

// File: tb/tb_wb_port_arb.sv
// tb_wb_port_arb: directed self-checking bench for wb_port_arb
module tb_wb_port_arb;
  logic clk = 1'b0;
  logic rst, stall;
  logic [2:0] req_vld, req_rdy;
  logic [4:0] a [3];
  logic [31:0] d [3];
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic wb_en;
  logic [4:0] wb_addr;
  logic [31:0] wb_data;
  logic [3:0] cont_cnt;
  int tests = 0;
  int fails = 0;
  assign req_addr = {a[2], a[1], a[0]};
  assign req_data = {d[2], d[1], d[0]};
  always #5 clk = ~clk;
  wb_port_arb #(.NREQ(3), .AW(5), .DW(32), .CW(4)) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .req_vld(req_vld),
    .req_addr(req_addr),
    .req_data(req_data),
    .req_rdy(req_rdy),
    .wb_en(wb_en),
    .wb_addr(wb_addr),
    .wb_data(wb_data),
    .cont_cnt(cont_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    stall = 1'b0;
    req_vld = 3'b111;
    for (int i = 0; i < 3; i++) begin
      a[i] = 5'd0;
      d[i] = 32'd0;
    end
    tick;
    chk("rst_rdy", 32'(req_rdy), 32'h0);
    tick;
    chk("rst_en", 32'(wb_en), 32'h0);
    chk("rst_addr", 32'(wb_addr), 32'h0);
    chk("rst_data", wb_data, 32'h0);
    chk("rst_cnt", 32'(cont_cnt), 32'h0);
    rst = 1'b0;
    req_vld = 3'b010;
    a[1] = 5'd5;
    d[1] = 32'hDEAD_BEEF;
    #1 chk("single_rdy", 32'(req_rdy), 32'h2);
    tick;
    chk("single_en", 32'(wb_en), 32'h1);
    chk("single_addr", 32'(wb_addr), 32'h5);
    chk("single_data", wb_data, 32'hDEAD_BEEF);
    chk("single_cnt", 32'(cont_cnt), 32'h0);
    req_vld = 3'b011;
    a[0] = 5'd7;
    d[0] = 32'h11;
    #1 chk("ptr2_rdy", 32'(req_rdy), 32'h1);
    tick;
    chk("ptr2_addr", 32'(wb_addr), 32'h7);
    chk("ptr2_cnt", 32'(cont_cnt), 32'h1);
    req_vld = 3'b100;
    #1 chk("align_rdy", 32'(req_rdy), 32'h4);
    tick;
    req_vld = 3'b111;
    for (int i = 0; i < 3; i++) begin
      a[i] = 5'(i + 1);
      d[i] = 32'hA0 + 32'(i);
    end
    for (int i = 0; i < 6; i++) begin
      #1 chk("rot_rdy", 32'(req_rdy), 32'(1 << (i % 3)));
      tick;
      chk("rot_en", 32'(wb_en), 32'h1);
      chk("rot_addr", 32'(wb_addr), 32'(i % 3 + 1));
      chk("rot_data", wb_data, 32'hA0 + 32'(i % 3));
    end
    chk("rot_cnt", 32'(cont_cnt), 32'h7);
    req_vld = 3'b001;
    a[0] = 5'd0;
    d[0] = 32'h1;
    #1 chk("x0_rdy", 32'(req_rdy), 32'h1);
    tick;
    chk("x0_en", 32'(wb_en), 32'h0);
    chk("x0_data", wb_data, 32'h1);
    req_vld = 3'b101;
    a[0] = 5'd9;
    d[0] = 32'h99;
    a[2] = 5'd12;
    d[2] = 32'hCC;
    #1 chk("x0_ptr_rdy", 32'(req_rdy), 32'h4);
    tick;
    chk("x0_ptr_addr", 32'(wb_addr), 32'hC);
    chk("x0_ptr_cnt", 32'(cont_cnt), 32'h8);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_rdy", 32'(req_rdy), 32'h0);
      tick;
      chk("stall_en", 32'(wb_en), 32'h0);
      chk("stall_addr", 32'(wb_addr), 32'hC);
      chk("stall_cnt", 32'(cont_cnt), 32'h8);
    end
    stall = 1'b0;
    #1 chk("unstall_rdy0", 32'(req_rdy), 32'h1);
    tick;
    chk("unstall_addr0", 32'(wb_addr), 32'h9);
    chk("unstall_cnt0", 32'(cont_cnt), 32'h9);
    #1 chk("unstall_rdy2", 32'(req_rdy), 32'h4);
    stall = 1'b1;
    #1 chk("stall_toggle_rdy", 32'(req_rdy), 32'h0);
    stall = 1'b0;
    #1 chk("unstall_rdy2b", 32'(req_rdy), 32'h4);
    tick;
    chk("unstall_addr2", 32'(wb_addr), 32'hC);
    chk("unstall_cnt2", 32'(cont_cnt), 32'hA);
    req_vld = 3'b111;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (i == 4) chk("sat_reach", 32'(cont_cnt), 32'hF);
    end
    chk("sat_hold", 32'(cont_cnt), 32'hF);
    rst = 1'b1;
    #1 chk("midrst_rdy", 32'(req_rdy), 32'h0);
    tick;
    chk("midrst_en", 32'(wb_en), 32'h0);
    chk("midrst_cnt", 32'(cont_cnt), 32'h0);
    rst = 1'b0;
    #1 chk("postrst_rdy", 32'(req_rdy), 32'h1);
    tick;
    chk("postrst_en", 32'(wb_en), 32'h1);
    chk("postrst_addr", 32'(wb_addr), 32'h9);
    chk("postrst_cnt", 32'(cont_cnt), 32'h1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wb_port_arb.md
# wb_port_arb

Round-robin arbiter for the single register-file write port of the RISC-V core. It shares the write port between up to NREQ writeback sources (ALU, LSU, MUL/DIV, CSR) and grants one source per cycle through a valid/ready handshake. The winning write is registered toward the register file. It sits between the execute/memory stage writeback outputs and the regfile write port.

## Interface
- NREQ, 3, number of requesters (2..4)
- AW, 5, register index width
- DW, 32, data width
- CW, 16, width of the contention counter
- clk  input  1  clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- stall  input  1  blocks all grants this cycle (debug halt, regfile port busy)
- req_vld  input  NREQ  request valid, one bit per source
- req_addr  input  NREQ*AW  destination index; source i occupies bits [i*AW +: AW]
- req_data  input  NREQ*DW  write data; source i occupies bits [i*DW +: DW]
- req_rdy  output  NREQ  grant, one-hot or zero; combinational
- wb_en  output  1  register-file write enable, registered
- wb_addr  output  AW  register-file write index, registered
- wb_data  output  DW  register-file write data, registered
- cont_cnt  output  CW  count of contention cycles, saturating, registered

## Operation
- **Priority pointer.** The 2-bit `ptr` (range 0..NREQ-1) names the highest-priority source.
  - Search order is ptr, ptr+1, …, wrapping modulo NREQ.
- **Grant.** When stall=0, the first source in search order with req_vld=1 gets req_rdy=1. All other req_rdy bits are 0.
  - When stall=1, or no source is valid, req_rdy=0.
- **Transfer.** A transfer occurs when req_vld[g] & req_rdy[g].
  - Sources must hold vld/addr/data stable until they see rdy.
  - A source may drop vld before it is granted.
- **Pointer update.** On a transfer, ptr <= (g+1) mod NREQ. Otherwise ptr holds.
- **Write output.** On the edge after a transfer:
  - wb_addr <= req_addr[g]
  - wb_data <= req_data[g]
  - wb_en <= (req_addr[g] != 0)
  - A write to x0 is accepted (handshake completes) but produces wb_en=0.
- **No transfer.** wb_en <= 0. wb_addr and wb_data hold their previous values.
- **Contention counter.** cont_cnt increments by 1 in any cycle with stall=0 and two or more req_vld bits set. It saturates at 2^CW-1 and never wraps.
- **Stall with requests pending.** No grant is made, ptr holds, and cont_cnt does not count.

## Timing
- Request-to-grant is combinational: 0 cycles, with req_rdy valid in the same cycle.
- Grant-to-write is 1 cycle: wb_* are asserted in the cycle after the transfer.
- Throughput is one write per cycle. There is no bubble between back-to-back grants.
- Reset values: wb_en=0, wb_addr=0, wb_data=0, cont_cnt=0, ptr=0, req_rdy=0 while rst=1.
- Reset mid-operation:
  - A transfer in the reset cycle is dropped; rst forces req_rdy=0.
  - Requesters keep their vld asserted and are re-arbitrated starting from source 0 after reset.
- Simultaneous events: with all NREQ sources valid continuously, grants rotate 0,1,2,0,1,2,… and no source waits more than NREQ-1 cycles.
- stall may toggle in any cycle. Its effect on req_rdy is immediate, in the same cycle.

## Structure
- Shared package `wb_arb_pkg` holds:
  - default NREQ, AW and DW constants
  - a function that extracts slot i of a packed bus
- The sub-module `gnrl_rr_pick` is combinational. It takes vld[NREQ] and ptr, and returns a one-hot grant plus a found flag and the binary grant index.
- The top level contains:
  - the ptr register
  - the wb_* output registers
  - the cont_cnt register
  - all registers use synchronous reset and are written in a single clocked process.
- Estimated size is about 150–250 lines of RTL.

## Test plan
1. **Single source.** Reset, then req_vld=3'b010, addr=5, data=32'hDEAD_BEEF → req_rdy=3'b010 in the same cycle; next cycle wb_en=1, wb_addr=5, wb_data=DEAD_BEEF; ptr becomes 2.
2. **Rotation.** req_vld=3'b111 held for 6 cycles → grants 0,1,2,0,1,2; wb_en=1 each following cycle; cont_cnt=6.
3. **x0 write.** Source 0 requests addr=0, data=1 → req_rdy[0]=1; next cycle wb_en=0; ptr advances to 1.
4. **Stall.** req_vld=3'b101 with stall=1 for 3 cycles → req_rdy=0, wb_en=0, cont_cnt unchanged. Release stall with ptr=0 → source 0 granted, then source 2.
5. **Counter saturation.** CW=4 with 20 contention cycles → cont_cnt stops at 15.
6. **Reset mid-operation.** Assert rst for 1 cycle during a 3'b111 burst → that cycle has req_rdy=0; next cycle wb_en=0 and cont_cnt=0; after release, the first grant goes to source 0.
